gpio_irq_det: RTL and testbench

Input-side front end for the GPIO core. It sits between the pads and the GPIO register block.
- Synchronises raw pad inputs and produces the clean value read back through PADIN.
- Detects per-pin level/edge interrupt events according to INTEN/INTTYPE0/INTTYPE1.
- Holds sticky INTSTATUS bits and drives the aggregated irq_o.

---
 rtl/gpio_pkg.sv | 14 +
 rtl/gpio_debounce.sv | 32 +++
 rtl/gpio_irq_det.sv | 125 ++++++++++++
 tb/tb_gpio_irq_det.sv | 279 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/gpio_pkg.sv
// Shared types and default constants for the GPIO input front end.
package gpio_pkg;

    typedef enum logic [1:0] {
        GPIO_INT_LVL_HIGH = 2'b00,
        GPIO_INT_LVL_LOW  = 2'b01,
        GPIO_INT_RISE     = 2'b10,
        GPIO_INT_FALL     = 2'b11
    } gpio_int_type_e;

    localparam int unsigned GPIO_SYNC_STAGES  = 2;
    localparam int unsigned GPIO_DEBOUNCE_CNT = 16;

endpackage

// File: rtl/gpio_debounce.sv
// Single-pin counter filter: level follows sample only after it has differed
// for DEBOUNCE_CNT consecutive cycles.
module gpio_debounce
    import gpio_pkg::*;
#(
    parameter int unsigned DEBOUNCE_CNT = GPIO_DEBOUNCE_CNT
) (
    input  logic clk_i,
    input  logic rst_i,
    input  logic sample,
    output logic level
);

    localparam int unsigned CW = $clog2(DEBOUNCE_CNT + 1);

    logic [CW-1:0] cnt_q;

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            cnt_q <= '0;
            level <= 1'b0;
        end else if (sample == level) begin
            cnt_q <= '0;
        end else if (cnt_q == CW'(DEBOUNCE_CNT - 1)) begin
            level <= sample;
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_q + CW'(1);
        end
    end

endmodule

// File: rtl/gpio_irq_det.sv
// GPIO input front end: pad synchroniser, interrupt event detection, sticky status, irq.
// Define GPIO_DEBOUNCE_EN to insert a per-pin gpio_debounce filter before pad_in_o.
module gpio_irq_det
    import gpio_pkg::*;
#(
    parameter int unsigned GPIO_NUM     = 32,
    parameter int unsigned SYNC_STAGES  = GPIO_SYNC_STAGES,
    parameter int unsigned DEBOUNCE_CNT = GPIO_DEBOUNCE_CNT
) (
    input  logic                clk_i,
    input  logic                rst_i,
    input  logic [GPIO_NUM-1:0] gpio_in_i,
    input  logic [GPIO_NUM-1:0] inten_i,
    input  logic [GPIO_NUM-1:0] inttype0_i,
    input  logic [GPIO_NUM-1:0] inttype1_i,
    input  logic                status_clr_i,
    output logic [GPIO_NUM-1:0] pad_in_o,
    output logic [GPIO_NUM-1:0] status_o,
    output logic                irq_o
);

    localparam int unsigned WARM_MAX = SYNC_STAGES + 1;
    localparam int unsigned WARM_W   = $clog2(WARM_MAX + 1);

    if (GPIO_NUM < 1 || GPIO_NUM > 32 || SYNC_STAGES < 2 || DEBOUNCE_CNT < 1) begin : g_bad_cfg
        $error("gpio_irq_det: unsupported parameter set");
    end

    logic [GPIO_NUM-1:0] sync_q [SYNC_STAGES];
    logic [GPIO_NUM-1:0] pad;
    logic [GPIO_NUM-1:0] prev_q;
    logic [GPIO_NUM-1:0] rise;
    logic [GPIO_NUM-1:0] fall;
    logic [GPIO_NUM-1:0] status_q;
    logic [GPIO_NUM-1:0] status_d;
    logic [WARM_W-1:0]   warm_q;
    logic                warm_done;
    logic                irq_q;

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            for (int unsigned s = 0; s < SYNC_STAGES; s++) begin
                sync_q[s] <= '0;
            end
        end else begin
            sync_q[0] <= gpio_in_i;
            for (int unsigned s = 1; s < SYNC_STAGES; s++) begin
                sync_q[s] <= sync_q[s-1];
            end
        end
    end

`ifdef GPIO_DEBOUNCE_EN
    for (genvar g = 0; g < GPIO_NUM; g++) begin : g_deb
        gpio_debounce #(
            .DEBOUNCE_CNT(DEBOUNCE_CNT)
        ) u_deb (
            .clk_i (clk_i),
            .rst_i (rst_i),
            .sample(sync_q[SYNC_STAGES-1][g]),
            .level (pad[g])
        );
    end
`else
    assign pad = sync_q[SYNC_STAGES-1];
`endif

    // Zeroed synchroniser looks like a rising edge on any pad high out of reset.
    assign warm_done = (warm_q == WARM_W'(WARM_MAX));

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            warm_q   <= '0;
            prev_q   <= '0;
            status_q <= '0;
            irq_q    <= 1'b0;
        end else begin
            if (!warm_done) begin
                warm_q <= warm_q + WARM_W'(1);
            end
            prev_q   <= pad;
            status_q <= status_d;
            irq_q    <= |status_q;
        end
    end

    always_comb begin : status_next
        gpio_int_type_e typ;
        logic           edge_evt;
        logic           lvl_evt;
        typ      = GPIO_INT_LVL_HIGH;
        edge_evt = 1'b0;
        lvl_evt  = 1'b0;
        rise     = pad & ~prev_q;
        fall     = ~pad & prev_q;
        status_d = status_q;
        for (int unsigned i = 0; i < GPIO_NUM; i++) begin
            typ      = gpio_int_type_e'({inttype1_i[i], inttype0_i[i]});
            edge_evt = 1'b0;
            lvl_evt  = 1'b0;
            case (typ)
                GPIO_INT_LVL_HIGH: lvl_evt  = pad[i];
                GPIO_INT_LVL_LOW:  lvl_evt  = ~pad[i];
                GPIO_INT_RISE:     edge_evt = rise[i];
                GPIO_INT_FALL:     edge_evt = fall[i];
                default:           edge_evt = 1'b0;
            endcase
            // Edge events beat a clear; a persisting level yields to it for one cycle.
            if (!inten_i[i]) begin
                status_d[i] = 1'b0;
            end else if (warm_done && edge_evt) begin
                status_d[i] = 1'b1;
            end else if (status_clr_i) begin
                status_d[i] = 1'b0;
            end else if (warm_done && lvl_evt) begin
                status_d[i] = 1'b1;
            end
        end
    end

    assign pad_in_o = pad;
    assign status_o = status_q;
    assign irq_o    = irq_q;

endmodule

// File: tb/tb_gpio_irq_det.sv
// Scoreboard bench for gpio_irq_det: expectations queued at stimulus time, checked per cycle.
// Honours GPIO_DEBOUNCE_EN for pad latency and the glitch-filter scenarios.
module tb_gpio_irq_det;
    import gpio_pkg::*;

    localparam int unsigned N = 32;
`ifdef GPIO_DEBOUNCE_EN
    localparam int LAT      = GPIO_SYNC_STAGES + GPIO_DEBOUNCE_CNT;
    localparam int WARM_WIN = LAT;
`else
    localparam int LAT      = GPIO_SYNC_STAGES;
    localparam int WARM_WIN = 20;
`endif
    localparam int SIG_PAD = 0;
    localparam int SIG_STS = 1;
    localparam int SIG_IRQ = 2;

    logic         clk;
    logic         rst;
    logic [N-1:0] gpio_in;
    logic [N-1:0] inten;
    logic [N-1:0] inttype0;
    logic [N-1:0] inttype1;
    logic         status_clr;
    logic [N-1:0] pad_in;
    logic [N-1:0] status;
    logic         irq;

    gpio_irq_det #(
        .GPIO_NUM    (N),
        .SYNC_STAGES (GPIO_SYNC_STAGES),
        .DEBOUNCE_CNT(GPIO_DEBOUNCE_CNT)
    ) dut (
        .clk_i       (clk),
        .rst_i       (rst),
        .gpio_in_i   (gpio_in),
        .inten_i     (inten),
        .inttype0_i  (inttype0),
        .inttype1_i  (inttype1),
        .status_clr_i(status_clr),
        .pad_in_o    (pad_in),
        .status_o    (status),
        .irq_o       (irq)
    );

    typedef struct {
        int          at;
        int          sig;
        logic [31:0] val;
        string       tag;
    } exp_t;

    exp_t        sb[$];
    int          cyc = 0;
    int          checks = 0;
    int          errors = 0;
    logic [31:0] obs;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] want);
        checks++;
        if (got !== want) begin
            errors++;
            $display("FAIL %s: got %h expected %h (cycle %0d)", tag, got, want, cyc);
        end
    endtask

    task automatic sb_push(input string tag, input int at, input int sig, input logic [31:0] val);
        sb.push_back('{at, sig, val, tag});
    endtask

    task automatic step(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    always @(negedge clk) begin
        for (int i = sb.size() - 1; i >= 0; i--) begin
            if (sb[i].at == cyc) begin
                case (sb[i].sig)
                    SIG_PAD: obs = pad_in;
                    SIG_STS: obs = status;
                    default: obs = {31'd0, irq};
                endcase
                check(sb[i].tag, obs, sb[i].val);
                sb.delete(i);
            end
        end
    end

    initial begin
        int b;
        int m;
        int s;
        rst        = 1'b1;
        gpio_in    = '1;
        inten      = '1;
        inttype1   = '1;
        inttype0   = '0;
        status_clr = 1'b0;
        step(3);
        check("rst_pad", pad_in, 32'd0);
        check("rst_sts", status, 32'd0);
        check("rst_irq", {31'd0, irq}, 32'd0);

        // Pads high out of reset with rising-edge type: warm-up must hide the edge.
        rst = 1'b0;
        b = cyc;
        sb_push("warm_pad_lo", b + LAT - 1, SIG_PAD, 32'd0);
        sb_push("warm_pad_hi", b + LAT, SIG_PAD, 32'hFFFF_FFFF);
        for (int k = 1; k <= WARM_WIN; k++) begin
            sb_push("warm_sts", b + k, SIG_STS, 32'd0);
            sb_push("warm_irq", b + k, SIG_IRQ, 32'd0);
        end
        step(WARM_WIN);

        // Pin 3 rising edge, then clear.
        inten   = '0;
        gpio_in = '0;
        step(LAT + 3);
        inten = 32'd1 << 3;
        step(2);
        gpio_in = 32'd1 << 3;
        b = cyc;
        sb_push("rise_pad_lo", b + LAT - 1, SIG_PAD, 32'd0);
        sb_push("rise_pad_hi", b + LAT, SIG_PAD, 32'h8);
        sb_push("rise_sts_pre", b + LAT, SIG_STS, 32'd0);
        sb_push("rise_sts", b + LAT + 1, SIG_STS, 32'h8);
        sb_push("rise_irq_pre", b + LAT + 1, SIG_IRQ, 32'd0);
        sb_push("rise_irq", b + LAT + 2, SIG_IRQ, 32'd1);
        step(LAT + 4);
        status_clr = 1'b1;
        m = cyc;
        sb_push("clr_sts_hold", m, SIG_STS, 32'h8);
        sb_push("clr_sts", m + 1, SIG_STS, 32'd0);
        sb_push("clr_irq_lag", m + 1, SIG_IRQ, 32'd1);
        sb_push("clr_irq", m + 2, SIG_IRQ, 32'd0);
        sb_push("clr_sts_stay", m + 3, SIG_STS, 32'd0);
        step(1);
        status_clr = 1'b0;
        step(4);

        // Pin 5 level high: clear drops it for one cycle only.
        inten    = '0;
        gpio_in  = 32'd1 << 5;
        inttype1 = '0;
        inttype0 = '0;
        step(LAT + 3);
        inten = 32'd1 << 5;
        b = cyc;
        sb_push("lvl_sts_pre", b, SIG_STS, 32'd0);
        sb_push("lvl_sts", b + 1, SIG_STS, 32'h20);
        sb_push("lvl_irq", b + 2, SIG_IRQ, 32'd1);
        step(3);
        status_clr = 1'b1;
        m = cyc;
        sb_push("lvl_clr_hold", m, SIG_STS, 32'h20);
        sb_push("lvl_clr_sts", m + 1, SIG_STS, 32'd0);
        sb_push("lvl_reset_sts", m + 2, SIG_STS, 32'h20);
        sb_push("lvl_clr_irq_hi", m + 1, SIG_IRQ, 32'd1);
        sb_push("lvl_clr_irq_lo", m + 2, SIG_IRQ, 32'd0);
        sb_push("lvl_clr_irq_re", m + 3, SIG_IRQ, 32'd1);
        step(1);
        status_clr = 1'b0;
        step(3);
        inten = '0;
        m = cyc;
        sb_push("inten_off_sts", m + 1, SIG_STS, 32'd0);
        sb_push("inten_off_irq_lag", m + 1, SIG_IRQ, 32'd1);
        sb_push("inten_off_irq", m + 2, SIG_IRQ, 32'd0);
        step(4);

        // Pin 0 falling edge coinciding with a clear: set wins.
        gpio_in  = 32'd1;
        inttype1 = '1;
        inttype0 = '1;
        step(LAT + 3);
        inten = 32'd1;
        step(2);
        gpio_in = '0;
        b = cyc;
        sb_push("fall_pad_hi", b + LAT - 1, SIG_PAD, 32'd1);
        sb_push("fall_pad_lo", b + LAT, SIG_PAD, 32'd0);
        sb_push("fall_sts_pre", b + LAT, SIG_STS, 32'd0);
        sb_push("fall_set_wins", b + LAT + 1, SIG_STS, 32'd1);
        sb_push("fall_sts_hold", b + LAT + 2, SIG_STS, 32'd1);
        sb_push("fall_irq", b + LAT + 2, SIG_IRQ, 32'd1);
        step(LAT);
        status_clr = 1'b1;
        step(1);
        status_clr = 1'b0;
        step(4);

        // Pin 7 held high, type switched rise->fall: no false edge.
        inten    = '0;
        gpio_in  = 32'd1 << 7;
        inttype1 = '1;
        inttype0 = '0;
        step(LAT + 3);
        inten = 32'd1 << 7;
        step(2);
        inttype0 = '1;
        b = cyc;
        for (int k = 1; k <= 4; k++) begin
            sb_push("type_sw_sts", b + k, SIG_STS, 32'd0);
            sb_push("type_sw_irq", b + k + 1, SIG_IRQ, 32'd0);
        end
        step(5);
        gpio_in = '0;
        b = cyc;
        sb_push("type_fall_pre", b + LAT, SIG_STS, 32'd0);
        sb_push("type_fall_sts", b + LAT + 1, SIG_STS, 32'h80);
        sb_push("type_fall_irq", b + LAT + 2, SIG_IRQ, 32'd1);
        step(LAT + 3);

        // Asynchronous reset mid-operation, then warm-up with a level-high pad.
        #2;
        rst = 1'b1;
        #1;
        check("async_rst_sts", status, 32'd0);
        check("async_rst_irq", {31'd0, irq}, 32'd0);
        check("async_rst_pad", pad_in, 32'd0);
        gpio_in  = 32'd1 << 9;
        inten    = 32'd1 << 9;
        inttype1 = '0;
        inttype0 = '0;
        step(2);
        rst = 1'b0;
        b = cyc;
        s = (LAT + 1 > 4) ? b + LAT + 1 : b + 4;
        sb_push("rewarm_pad", b + LAT, SIG_PAD, 32'h200);
        for (int k = 1; b + k < s; k++) begin
            sb_push("rewarm_sts_sup", b + k, SIG_STS, 32'd0);
        end
        sb_push("rewarm_sts", s, SIG_STS, 32'h200);
        sb_push("rewarm_irq_pre", s, SIG_IRQ, 32'd0);
        sb_push("rewarm_irq", s + 1, SIG_IRQ, 32'd1);
        step(LAT + 6);

`ifdef GPIO_DEBOUNCE_EN
        // Pin 2: short glitch rejected, long pulse accepted.
        inten    = '0;
        gpio_in  = '0;
        inttype1 = '1;
        inttype0 = '0;
        step(LAT + 3);
        inten = 32'd1 << 2;
        step(2);
        gpio_in = 32'd1 << 2;
        b = cyc;
        for (int k = 1; k <= 40; k++) begin
            sb_push("glitch_pad", b + k, SIG_PAD, 32'd0);
            sb_push("glitch_sts", b + k, SIG_STS, 32'd0);
        end
        step(10);
        gpio_in = '0;
        step(35);
        gpio_in = 32'd1 << 2;
        b = cyc;
        sb_push("deb_pad_lo", b + LAT - 1, SIG_PAD, 32'd0);
        sb_push("deb_pad_hi", b + LAT, SIG_PAD, 32'h4);
        sb_push("deb_sts", b + LAT + 1, SIG_STS, 32'h4);
        step(LAT + 3);
`endif

        for (int k = 0; k < 50 && sb.size() > 0; k++) begin
            step(1);
        end
        check("sb_drain", 32'(sb.size()), 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
